// File: rtl/fetch_decode_seq.sv
// rtl/fetch_decode_seq.sv - fetch/decode/interrupt sequencer with fixed-priority vectored IRQs
// Optional wait-state watchdog with sticky err: define FDS_WATCHDOG_EN.
module fetch_decode_seq #(
   parameter int                IRQ_LINES  = 4,
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0200,
   parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0010,
   parameter int                TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [IRQ_LINES-1:0] irq,
   input  logic [IRQ_LINES-1:0] irq_mask,
   input  logic [ADDR_W-1:0]    pc_in,
   output logic                 fcu_req,
   output logic                 fcu_sel,
   input  logic                 fcu_ready,
   output logic                 dec_req,
   input  logic                 dec_ready,
   output logic                 stk_req,
   output logic                 stk_push,
   output logic [ADDR_W-1:0]    stk_data,
   input  logic                 stk_ready,
   output logic                 pc_load,
   output logic [ADDR_W-1:0]    pc_vec,
   output logic [IRQ_LINES-1:0] irq_ack,
   output logic                 busy,
   output logic                 err
);

   localparam int IDX_W = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;

   typedef enum logic [3:0] {
      IDLE, CHECK, F_REQ, F_WAIT, D_REQ, D_WAIT, IRQ_PUSH, IRQ_WAIT, IRQ_VEC
   } state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     pend_idx;
   logic [IRQ_LINES-1:0] pend;
   logic                 pend_any;
   logic                 wait_st;
   logic                 cur_ready;
   logic                 wd_trip;

   assign pend     = irq & irq_mask;
   assign pend_any = |pend;

   // Scan downwards so the lowest pending index is the one left standing.
   always_comb begin
      pend_idx = '0;
      for (int i = IRQ_LINES - 1; i >= 0; i--) begin
         if (pend[i]) pend_idx = IDX_W'(i);
      end
   end

   assign wait_st = (state == F_WAIT) || (state == D_WAIT) || (state == IRQ_WAIT);

   always_comb begin
      cur_ready = 1'b0;
      case (state)
         F_WAIT:   cur_ready = fcu_ready;
         D_WAIT:   cur_ready = dec_ready;
         IRQ_WAIT: cur_ready = stk_ready;
         default:  cur_ready = 1'b0;
      endcase
   end

`ifdef FDS_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;

   assign wd_trip = wait_st && !cur_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
   assign err     = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_nxt != state) wd_cnt <= '0;
         else if (wait_st)       wd_cnt <= wd_cnt + 1'b1;
         if (wd_trip) err_q <= 1'b1;
      end
   end
`else
   assign wd_trip = 1'b0;
   assign err     = 1'b0;
`endif

   // A tripped watchdog parks the sequencer in IDLE until reset.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (run && !err) state_nxt = CHECK;
         CHECK: begin
            if (pend_any)  state_nxt = IRQ_PUSH;
            else if (!run) state_nxt = IDLE;
            else           state_nxt = F_REQ;
         end
         F_REQ:    state_nxt = F_WAIT;
         F_WAIT:   if (cur_ready) state_nxt = D_REQ;  else if (wd_trip) state_nxt = IDLE;
         D_REQ:    state_nxt = D_WAIT;
         D_WAIT:   if (cur_ready) state_nxt = CHECK;  else if (wd_trip) state_nxt = IDLE;
         IRQ_PUSH: state_nxt = IRQ_WAIT;
         IRQ_WAIT: if (cur_ready) state_nxt = IRQ_VEC; else if (wd_trip) state_nxt = IDLE;
         IRQ_VEC:  state_nxt = F_REQ;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         idx_q    <= '0;
         stk_data <= '0;
      end else begin
         state <= state_nxt;
         if (state == CHECK && pend_any) begin
            idx_q    <= pend_idx;
            stk_data <= pc_in;
         end
      end
   end

   assign fcu_req  = (state == F_REQ);
   assign fcu_sel  = (state == F_REQ) || (state == F_WAIT);
   assign dec_req  = (state == D_REQ);
   assign stk_req  = (state == IRQ_PUSH);
   assign stk_push = (state == IRQ_PUSH) || (state == IRQ_WAIT);
   assign pc_load  = (state == IRQ_VEC);
   assign pc_vec   = (state == IRQ_VEC) ? (VEC_BASE + ADDR_W'(idx_q) * VEC_STRIDE) : '0;
   assign irq_ack  = (state == IRQ_VEC) ? (IRQ_LINES'(1) << idx_q) : '0;
   assign busy     = (state != IDLE);

endmodule

// File: doc/fetch_decode_seq.md
Name: fetch_decode_seq

Overview:
- Parametrised fetch/decode/interrupt sequencer for the MCU control path; successor to the single-line fetch-decode control unit.
- Drives the fetch unit, the decoder and the return-address stack through req/ready handshakes.
- Arbitrates IRQ_LINES maskable interrupt lines by fixed priority and generates a per-line vector address.
- All outputs are driven to defined 0/1 levels at all times; nothing is tri-stated.

Parameters:
- IRQ_LINES, 4, number of interrupt request lines (1..8).
- ADDR_W, 16, PC, vector and stack data width.
- VEC_BASE, 16'h0200, vector address of line 0.
- VEC_STRIDE, 16'h0010, address spacing between consecutive line vectors.
- TIMEOUT, 255, watchdog limit in cycles per wait state (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; sequencer leaves IDLE only while 1
- irq  in  IRQ_LINES  level interrupt requests
- irq_mask  in  IRQ_LINES  1 = line enabled
- pc_in  in  ADDR_W  current PC, pushed on interrupt entry
- fcu_req  out  1  fetch request pulse
- fcu_sel  out  1  fetch source select, 1 = program memory
- fcu_ready  in  1  fetch complete
- dec_req  out  1  decode request pulse
- dec_ready  in  1  decode complete
- stk_req  out  1  stack request pulse
- stk_push  out  1  1 = push operation
- stk_data  out  ADDR_W  data to push
- stk_ready  in  1  stack operation complete
- pc_load  out  1  one-cycle pulse: load pc_vec into PC
- pc_vec  out  ADDR_W  vector address
- irq_ack  out  IRQ_LINES  one-hot, one-cycle acknowledge
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog error (optional feature only; otherwise tied 0)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0, including stk_data, pc_vec and irq_ack. Reset asserted mid-handshake abandons the transaction immediately; no completion pulse is issued.
- IDLE: goes to CHECK when run=1.
- CHECK:
  - pend = irq & irq_mask.
  - If pend != 0: latch idx = lowest set bit (line 0 has highest priority), latch stk_data=pc_in, go to IRQ_PUSH.
  - Else if run=0: go to IDLE.
  - Else: go to F_REQ.
- F_REQ: fcu_req=1 and fcu_sel=1 for one cycle; go to F_WAIT.
- F_WAIT: hold until fcu_ready=1, then go to D_REQ. fcu_sel stays 1 until this state is left.
- D_REQ: dec_req=1 for one cycle; go to D_WAIT.
- D_WAIT: hold until dec_ready=1, then go to CHECK.
- IRQ_PUSH: stk_req=1 and stk_push=1 for one cycle; go to IRQ_WAIT.
- IRQ_WAIT: stk_push held at 1. On stk_ready=1, go to IRQ_VEC.
- IRQ_VEC:
  - pc_vec = VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - pc_load=1 and irq_ack[idx]=1 for one cycle.
  - Go to F_REQ; the first fetch after the vector is unconditional.
- Ready-signal rules:
  - A ready seen in the same cycle as its req pulse is ignored; ready is sampled only in the WAIT states.
  - Stray ready inputs in other states are ignored.
- Interrupt sampling:
  - Interrupts are sampled only in CHECK; requests arriving mid-fetch/decode wait for the next CHECK.
  - Simultaneous requests: the lowest index wins. Others remain pending while their irq stays high.
  - The line must drop irq after irq_ack; otherwise it re-enters at the next CHECK.
- Latency:
  - Instruction with zero-wait units: CHECK→F_REQ→F_WAIT→D_REQ→D_WAIT→CHECK = 5 cycles.
  - Interrupt entry from CHECK to pc_load = 3 cycles with zero-wait stack.
- run=0 takes effect only at CHECK; an in-flight fetch/decode completes first.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- FDS_WATCHDOG_EN defined:
  - A counter resets on every state entry and increments in F_WAIT, D_WAIT and IRQ_WAIT.
  - If it reaches TIMEOUT without a ready: go to IDLE, set err=1 (sticky until reset).
  - The aborted transaction's pulses are not reissued.
  - Recovery requires reset.
- Not defined: no counter exists, wait states hold indefinitely, err is constant 0.

Test Plan:
- Reset, run=1, fcu_ready/dec_ready returned 1 cycle after each req, no irq → fcu_req and dec_req each pulse once per 5 cycles; busy=1; all other outputs 0.
- irq=4'b0110, irq_mask=4'b1111, pc_in=16'h0123, stk_ready immediate:
  - stk_data=16'h0123 with stk_push=1.
  - Then pc_vec=16'h0210, pc_load=1 and irq_ack=4'b0010 in the same cycle.
  - Next state is F_REQ.
- irq=4'b0001, irq_mask=4'b1110 → no interrupt entry; normal fetch/decode continues.
- irq asserted during F_WAIT → entry is deferred until the first CHECK after dec_ready; no stk_req before then.
- reset driven low during D_WAIT → all outputs 0 asynchronously; after release with run=1, the first fcu_req appears 2 cycles later (IDLE→CHECK→F_REQ).
- With FDS_WATCHDOG_EN and TIMEOUT=8, fcu_ready held 0 → 8 cycles after entering F_WAIT: err=1, busy=0, no dec_req issued.
